output_capture: RTL and testbench
=================================

OUTPUT_CAPTURE -- requirements
Module: output_capture

Interface
REQ-001 Parameter DEPTH, default 16, entries per output channel FIFO (power of two, 2..256).
REQ-002 Parameter WIDTH, default 12, data width of one CPU output word.
REQ-003 clk  input  1  system clock (fast board clock, not the CPU step clock).
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 out_data  input  WIDTH  CPU OUT bus.
REQ-006 out_valid  input  1  CPU OUT_valid level.
REQ-007 out_select  input  1  CPU OUT_select; 0 = OUT1, 1 = OUT2.
REQ-008 step  input  1  one-clk pulse per CPU step (rising edge of CPU clock, clk-synchronous).
REQ-009 clr  input  1  synchronous clear of all capture state.
REQ-010 rd_en  input  1  host read request, one word per asserted cycle.
REQ-011 rd_sel  input  1  channel to read; 0 = OUT1, 1 = OUT2.
REQ-012 rd_data  output  WIDTH  word popped by the last accepted read.
REQ-013 rd_valid  output  1  one-cycle pulse: rd_data updated this cycle.
REQ-014 count1, count2  output  log2(DEPTH)+1  current occupancy per channel.
REQ-015 ovf  output  2  sticky overflow per channel, bit0 = OUT1, bit1 = OUT2.
REQ-016 last1, last2  output  WIDTH  most recent word written to each channel (for display).

Function
REQ-017 Capture event: out_valid & step in the same clk cycle; exactly one word per CPU step regardless of how long out_valid stays high.
REQ-018 Captured word goes to channel out_select; other channel untouched.
REQ-019 On capture, last1/last2 of the selected channel updates to out_data on the next clk edge, even if the FIFO is full.
REQ-020 Capture into a full channel with no same-cycle read of that channel: word dropped, FIFO unchanged, ovf bit for that channel set.
REQ-021 Capture into a full channel with same-cycle read of that channel: both happen; count unchanged; no overflow.
REQ-022 Read accepted when rd_en and count of rd_sel channel is nonzero; oldest word popped (FIFO order).
REQ-023 Read latency 1 clk: rd_data and rd_valid register on the edge after the accepting cycle; rd_valid high for exactly one cycle per accepted read.
REQ-024 Read of an empty channel ignored: rd_data holds, rd_valid stays low, counts unchanged, no flag set.
REQ-025 Simultaneous capture and read on an empty channel: read ignored, capture stored (no fall-through).
REQ-026 Read/write pointers wrap modulo DEPTH; count ranges 0..DEPTH inclusive.
REQ-027 ovf bits are sticky until clr or reset.
REQ-028 clr has priority over capture and read in the same cycle: both FIFOs emptied, ovf = 0, last1 = last2 = 0, rd_valid = 0; rd_data holds.
REQ-029 Storage contents are not cleared by clr/reset; only pointers and counts.

Reset
REQ-030 reset low asynchronously forces: counts 0, pointers 0, ovf 0, last1/last2 0, rd_data 0, rd_valid 0.
REQ-031 Reset asserted mid-operation discards all queued words; first capture after release lands at entry 0.
REQ-032 Outputs leave reset values only on the first clk edge after reset goes high.

Structure
REQ-033 Shared package holds WIDTH default (12), DEPTH default, and channel encodings CH_OUT1 = 0, CH_OUT2 = 1.
REQ-034 One sub-module out_fifo (single-clock synchronous FIFO: push, pop, dout registered, count, full, empty), instantiated twice; top holds capture qualification, read mux, ovf, last registers.
REQ-035 FIFO storage inferable as distributed RAM; no reset on the storage array.

Verification
REQ-036 out_valid=1, out_select=0, out_data=0x123 held 5 step periods with step pulsed once -> count1=1, last1=0x123, count2=0.
REQ-037 17 captures of 0x001..0x011 to OUT1 (DEPTH 16) -> count1=16, ovf=2'b01, last1=0x011; 16 reads return 0x001..0x010 in order, each rd_valid one cycle after rd_en.
REQ-038 Full OUT2 channel, capture 0xABC with rd_en, rd_sel=1 same cycle -> rd_data=oldest word, count2 stays 16, ovf[1]=0, 0xABC read last.
REQ-039 rd_en on empty OUT1 -> rd_valid stays 0, rd_data unchanged; capture + read same cycle on empty -> count1=1, rd_valid=0.
REQ-040 3 words queued in each channel, ovf set, then clr with simultaneous capture -> counts 0, ovf 0, last 0, captured word dropped.
REQ-041 reset pulsed low between clk edges with 5 words queued -> all outputs zero immediately; next capture 0x7FF then read returns 0x7FF.

Source files
------------

// File: rtl/output_capture_pkg.sv
// Shared definitions for the CPU output capture block: default sizes and
// the channel encodings used on out_select / rd_sel.
package output_capture_pkg;
  localparam int WIDTH_DEF = 12;
  localparam int DEPTH_DEF = 16;
  localparam logic CH_OUT1 = 1'b0;
  localparam logic CH_OUT2 = 1'b1;
endpackage

// File: rtl/output_capture_fifo.sv
// Single-clock FIFO for one output channel. The read word is registered, and
// the storage array has no reset so it can map onto distributed RAM.
module out_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~clr & ~empty;
  // A push into a full FIFO is only legal when a pop frees the slot that cycle.
  assign do_push = push & ~clr & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        dout   <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/output_capture.sv
// Captures one CPU OUT word per CPU step into one of two channel FIFOs and
// lets a host drain them; tracks sticky overflow and the last word per channel.
module output_capture
  import output_capture_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       out_data,
  input  logic                   out_valid,
  input  logic                   out_select,
  input  logic                   step,
  input  logic                   clr,
  input  logic                   rd_en,
  input  logic                   rd_sel,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_valid,
  output logic [$clog2(DEPTH):0] count1,
  output logic [$clog2(DEPTH):0] count2,
  output logic [1:0]             ovf,
  output logic [WIDTH-1:0]       last1,
  output logic [WIDTH-1:0]       last2
);
  logic             cap;
  logic             cap1, cap2;
  logic             rd1, rd2;
  logic             full1, full2;
  logic             empty1, empty2;
  logic [WIDTH-1:0] dout1, dout2;
  logic             rd_ch;

  // step is a single-clk pulse, so a level out_valid yields one word per step.
  assign cap  = out_valid & step;
  assign cap1 = cap & (out_select == CH_OUT1);
  assign cap2 = cap & (out_select == CH_OUT2);
  assign rd1  = rd_en & (rd_sel == CH_OUT1) & ~empty1;
  assign rd2  = rd_en & (rd_sel == CH_OUT2) & ~empty2;

  out_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo1 (
    .clk(clk), .reset(reset), .clr(clr),
    .push(cap1), .pop(rd1), .din(out_data),
    .dout(dout1), .count(count1), .full(full1), .empty(empty1)
  );

  out_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo2 (
    .clk(clk), .reset(reset), .clr(clr),
    .push(cap2), .pop(rd2), .din(out_data),
    .dout(dout2), .count(count2), .full(full2), .empty(empty2)
  );

  // Each FIFO holds its own last popped word; rd_ch remembers which one is current.
  assign rd_data = (rd_ch == CH_OUT2) ? dout2 : dout1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid <= 1'b0;
      rd_ch    <= CH_OUT1;
      ovf      <= 2'b00;
      last1    <= '0;
      last2    <= '0;
    end else if (clr) begin
      rd_valid <= 1'b0;
      ovf      <= 2'b00;
      last1    <= '0;
      last2    <= '0;
    end else begin
      rd_valid <= rd1 | rd2;
      if (rd1)      rd_ch <= CH_OUT1;
      else if (rd2) rd_ch <= CH_OUT2;
      if (cap1 & full1 & ~rd1) ovf[0] <= 1'b1;
      if (cap2 & full2 & ~rd2) ovf[1] <= 1'b1;
      if (cap1) last1 <= out_data;
      if (cap2) last2 <= out_data;
    end
  end
endmodule

// File: tb/tb_output_capture.sv
// Directed bench for output_capture with hand-computed expectations.
module tb_output_capture;
  localparam int DEPTH = 16;
  localparam int WIDTH = 12;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_select;
  logic             step;
  logic             clr;
  logic             rd_en;
  logic             rd_sel;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic [4:0]       count1;
  logic [4:0]       count2;
  logic [1:0]       ovf;
  logic [WIDTH-1:0] last1;
  logic [WIDTH-1:0] last2;

  int n_checks = 0;
  int n_fail   = 0;

  output_capture #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .out_data(out_data), .out_valid(out_valid),
    .out_select(out_select), .step(step), .clr(clr), .rd_en(rd_en),
    .rd_sel(rd_sel), .rd_data(rd_data), .rd_valid(rd_valid),
    .count1(count1), .count2(count2), .ovf(ovf), .last1(last1), .last2(last2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cap(input logic ch, input logic [WIDTH-1:0] d);
    out_valid  = 1'b1;
    out_select = ch;
    out_data   = d;
    step       = 1'b1;
    tick();
    step       = 1'b0;
    out_valid  = 1'b0;
  endtask

  task automatic rd(input logic ch);
    rd_en  = 1'b1;
    rd_sel = ch;
    tick();
    rd_en  = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; out_data = '0; out_valid = 1'b0; out_select = 1'b0;
    step = 1'b0; clr = 1'b0; rd_en = 1'b0; rd_sel = 1'b0;
    tick(); tick();
    check("rst_count1", 16'(count1), 16'd0);
    check("rst_count2", 16'(count2), 16'd0);
    check("rst_ovf", 16'(ovf), 16'd0);
    check("rst_rd_valid", 16'(rd_valid), 16'd0);
    check("rst_rd_data", 16'(rd_data), 16'd0);
    check("rst_last1", 16'(last1), 16'd0);
    reset = 1'b1;
    tick();

    // Long out_valid, single step pulse -> exactly one word
    out_valid = 1'b1; out_select = 1'b0; out_data = 12'h123;
    for (int p = 0; p < 5; p++) begin
      for (int k = 0; k < 3; k++) begin
        step = (p == 0 && k == 0);
        tick();
      end
    end
    step = 1'b0; out_valid = 1'b0;
    check("hold_count1", 16'(count1), 16'd1);
    check("hold_last1", 16'(last1), 16'h123);
    check("hold_count2", 16'(count2), 16'd0);
    do_clr();
    check("clr_count1", 16'(count1), 16'd0);

    // Overflow of OUT1 and in-order drain
    for (int i = 1; i <= 17; i++) cap(1'b0, 12'(i));
    check("ovf_count1", 16'(count1), 16'd16);
    check("ovf_flag", 16'(ovf), 16'b01);
    check("ovf_last1", 16'(last1), 16'h011);
    for (int i = 1; i <= 16; i++) begin
      rd(1'b0);
      check("drain_valid", 16'(rd_valid), 16'd1);
      check("drain_data", 16'(rd_data), 16'(i));
      tick();
      check("drain_valid_low", 16'(rd_valid), 16'd0);
    end
    check("drain_count1", 16'(count1), 16'd0);
    check("ovf_sticky", 16'(ovf), 16'b01);

    // Full OUT2 with simultaneous capture and read
    do_clr();
    for (int i = 0; i < 16; i++) cap(1'b1, 12'h200 + 12'(i));
    check("full2_count", 16'(count2), 16'd16);
    out_valid = 1'b1; out_select = 1'b1; out_data = 12'hABC; step = 1'b1;
    rd_en = 1'b1; rd_sel = 1'b1;
    tick();
    out_valid = 1'b0; step = 1'b0; rd_en = 1'b0;
    check("full_rw_data", 16'(rd_data), 16'h200);
    check("full_rw_valid", 16'(rd_valid), 16'd1);
    check("full_rw_count2", 16'(count2), 16'd16);
    check("full_rw_ovf", 16'(ovf), 16'b00);
    for (int i = 1; i < 16; i++) begin
      rd(1'b1);
      check("full_rw_drain", 16'(rd_data), 16'h200 + 16'(i));
    end
    rd(1'b1);
    check("full_rw_last", 16'(rd_data), 16'hABC);
    check("full_rw_empty", 16'(count2), 16'd0);

    // Reads of an empty channel
    do_clr();
    rd(1'b0);
    check("empty_rd_valid", 16'(rd_valid), 16'd0);
    check("empty_rd_data", 16'(rd_data), 16'hABC);
    check("empty_rd_count", 16'(count1), 16'd0);
    out_valid = 1'b1; out_select = 1'b0; out_data = 12'h055; step = 1'b1;
    rd_en = 1'b1; rd_sel = 1'b0;
    tick();
    out_valid = 1'b0; step = 1'b0; rd_en = 1'b0;
    check("empty_rw_count", 16'(count1), 16'd1);
    check("empty_rw_valid", 16'(rd_valid), 16'd0);
    check("empty_rw_data", 16'(rd_data), 16'hABC);
    rd(1'b0);
    check("empty_rw_read", 16'(rd_data), 16'h055);

    // clr beats a same-cycle capture
    do_clr();
    for (int i = 1; i <= 17; i++) cap(1'b0, 12'h100 + 12'(i));
    for (int i = 0; i < 13; i++) rd(1'b0);
    for (int i = 1; i <= 3; i++) cap(1'b1, 12'h300 + 12'(i));
    check("pre_clr_counts", {8'(count1), 8'(count2)}, 16'h0303);
    check("pre_clr_ovf", 16'(ovf), 16'b01);
    check("pre_clr_rd_data", 16'(rd_data), 16'h10D);
    out_valid = 1'b1; out_select = 1'b1; out_data = 12'h3AA; step = 1'b1; clr = 1'b1;
    tick();
    out_valid = 1'b0; step = 1'b0; clr = 1'b0;
    check("clr_counts", {8'(count1), 8'(count2)}, 16'h0000);
    check("clr_ovf", 16'(ovf), 16'b00);
    check("clr_last1", 16'(last1), 16'd0);
    check("clr_last2", 16'(last2), 16'd0);
    check("clr_rd_valid", 16'(rd_valid), 16'd0);
    check("clr_rd_data_hold", 16'(rd_data), 16'h10D);
    tick();
    check("clr_dropped", 16'(count2), 16'd0);

    // Asynchronous reset between clock edges
    for (int i = 1; i <= 6; i++) cap(1'b0, 12'h400 + 12'(i));
    rd(1'b0);
    check("pre_rst_data", 16'(rd_data), 16'h401);
    check("pre_rst_count", 16'(count1), 16'd5);
    #2 reset = 1'b0;
    #1;
    check("arst_count1", 16'(count1), 16'd0);
    check("arst_rd_data", 16'(rd_data), 16'd0);
    check("arst_last1", 16'(last1), 16'd0);
    check("arst_rd_valid", 16'(rd_valid), 16'd0);
    #1 reset = 1'b1;
    tick();
    cap(1'b0, 12'h7FF);
    check("post_rst_count", 16'(count1), 16'd1);
    rd(1'b0);
    check("post_rst_data", 16'(rd_data), 16'h7FF);
    check("post_rst_valid", 16'(rd_valid), 16'd1);
    check("post_rst_empty", 16'(count1), 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end
endmodule
